serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  WIDTH  minuend, captured on accepted start.
REQ-006 b  input  WIDTH  subtrahend, captured on accepted start.
REQ-007 bin  input  1  initial borrow-in, captured on accepted start.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 bout  output  1  final borrow-out; 1 iff a < b + bin (unsigned).

Function
REQ-012 FSM states IDLE, RUN, DONE; encoding free.
REQ-013 IDLE: start=1 at edge E0 loads a, b into shift registers, bin into borrow flop, clears bit counter, moves to RUN; start=0 stays in IDLE.
REQ-014 RUN: each edge processes one bit, LSB first, through one full-subtractor cell on (a_sh[0], b_sh[0], borrow).
REQ-015 RUN per edge: a_sh and b_sh shift right by one, cell difference shifts into result register MSB, borrow flop takes cell borrow-out, counter increments.
REQ-016 RUN lasts exactly WIDTH edges (E1..EWIDTH); on EWIDTH, FSM moves to DONE and diff, bout load from the result register and the borrow flop.
REQ-017 done registered, high exactly while in DONE: one cycle, asserted after edge EWIDTH; latency start-sample to done = WIDTH cycles.
REQ-018 DONE returns to IDLE on the next edge unconditionally; start in DONE is ignored.
REQ-019 start while busy is ignored; in-flight operands, counter and borrow are unaffected.
REQ-020 diff and bout hold their last values until the next completion; they are not disturbed during RUN.
REQ-021 busy = (state == RUN); busy and done are never high together.
REQ-022 Counter width clog2(WIDTH)+1; no wrap occurs within one operation.
REQ-023 a, b and bin are don't-care outside the accepting IDLE edge.

Reset
REQ-024 rst_n low asynchronously forces IDLE, busy=0, done=0, diff=0, bout=0, shift registers, counter and borrow to 0.
REQ-025 Reset mid-RUN aborts the operation with no done pulse; diff and bout read 0.
REQ-026 After rst_n deasserts, the first rising edge with start=1 is accepted normally.

Structure
REQ-027 The shared package holds the FSM state type/constants (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-028 The one-bit cell is the existing full_subtractor sub-module (ports diff, bout, a, b, bin), instantiated once; no other arithmetic sub-modules.
REQ-029 Registers: a_sh, b_sh, result shift register, borrow flop, counter, state, diff, bout, done.

Verification (WIDTH=8 unless stated)
REQ-030 a=0x05, b=0x03, bin=0, start pulse -> busy for 8 cycles, done one cycle later, diff=0x02, bout=0.
REQ-031 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
REQ-032 a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0; borrow ripples across the bit-3/bit-4 boundary.
REQ-033 start held high throughout, operands changed mid-RUN -> result reflects the first captured operands; next op starts only from IDLE, so the done-to-done period is WIDTH+2 cycles.
REQ-034 rst_n pulsed low at RUN cycle 4 -> all outputs 0 immediately, no done; next op 0x05-0x03 -> diff=0x02.
REQ-035 WIDTH=4, all 512 (a,b,bin) combinations -> diff and bout match the reference model a-b-bin mod 16, with borrow.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states and sizing.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter must be able to hold WIDTH itself without wrapping.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_if.sv
// Request/response bundle of the serial subtractor: operands in, status and result out.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface : serial_subtractor_if

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell walks the operands LSB first,
// taking WIDTH cycles per operation, then pulses done with diff/bout held stable.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int               CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] diff_q,   diff_d;
  logic             bout_q,   bout_d;
  logic             done_q,   done_d;

  logic             cell_diff;
  logic             cell_bout;

  full_subtractor u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  // NOTE: every next-state variable gets a hold default before the case, so no
  // path through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          borrow_d = bus.bin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_d    = {cell_diff, res_q[WIDTH-1:1]};
        borrow_d = cell_bout;
        cnt_d    = cnt_q + 1'b1;
        // Final bit: publish the completed result together with the last borrow.
        if (cnt_q == LAST) begin
          diff_d  = res_d;
          bout_d  = cell_bout;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed and random subtractions on WIDTH=8, exhaustive
// WIDTH=4, start-hold and mid-run reset, all against an integer reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;

  int errors = 0;
  int checks = 0;

  logic [7:0] last_d8;
  logic       last_b8;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic, wrapped modulo 2^w; borrow iff negative.
  function automatic void ref_sub(input int w, input longint a, input longint b,
                                  input longint bin, output logic [31:0] d,
                                  output logic br);
    longint raw;
    longint m;
    m   = longint'(1) << w;
    raw = a - b - bin;
    br  = (raw < 0);
    d   = 32'((raw + m) % m);
  endfunction

  task automatic junk8();
    bus8.start = 1'($urandom);
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.bin   = 1'($urandom);
  endtask

  // Full WIDTH=8 operation with cycle-exact checks of busy/done and result hold.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input string tag);
    logic [31:0] exp_d;
    logic        exp_b;
    ref_sub(8, longint'(a), longint'(b), longint'(bin), exp_d, exp_b);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.bin = bin;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      junk8();
      check({tag, "_busy"}, {62'd0, bus8.busy, bus8.done}, 64'b10);
      if (i == 4) begin
        check({tag, "_hold_diff"}, 64'(bus8.diff), 64'(last_d8));
        check({tag, "_hold_bout"}, 64'(bus8.bout), 64'(last_b8));
      end
    end
    @(negedge clk);
    check({tag, "_done"}, {62'd0, bus8.busy, bus8.done}, 64'b01);
    check({tag, "_diff"}, 64'(bus8.diff), 64'(exp_d[7:0]));
    check({tag, "_bout"}, 64'(bus8.bout), 64'(exp_b));
    last_d8 = exp_d[7:0];
    last_b8 = exp_b;
    junk8();
    @(negedge clk);
    bus8.start = 1'b0;
    check({tag, "_idle"}, {62'd0, bus8.busy, bus8.done}, 64'b00);
  endtask

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    logic [31:0] exp_d;
    logic        exp_b;
    int          lat;
    bit          seen;
    ref_sub(4, longint'(a), longint'(b), longint'(bin), exp_d, exp_b);
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.bin = bin;
    @(negedge clk);
    bus4.start = 1'b0; bus4.a = 4'($urandom); bus4.b = 4'($urandom);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      seen = bus4.done;
    end
    if (!seen) begin
      check("w4_timeout", 64'(seen), 64'd1);
    end else if (lat != 5) begin
      check("w4_latency", 64'(lat - 1), 64'd4);
    end else begin
      checks++;
      assert ({bus4.diff, bus4.bout} === {exp_d[3:0], exp_b}) else begin
        errors++;
        $error("FAIL w4_result a=%0h b=%0h bin=%0d: observed diff=%0h bout=%0d expected diff=%0h bout=%0d",
               a, b, bin, bus4.diff, bus4.bout, exp_d[3:0], exp_b);
      end
    end
  endtask

  initial begin
    int d1;
    int d2;
    int done_cnt;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
    last_d8 = '0;
    last_b8 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus8.busy), 64'd0);
    check("rst_done", 64'(bus8.done), 64'd0);
    check("rst_diff", 64'(bus8.diff), 64'd0);
    check("rst_bout", 64'(bus8.bout), 64'd0);
    check("rst_w4_out", {58'd0, bus4.busy, bus4.done, bus4.diff}, 64'd0);
    rst_n = 1'b1;

    // Directed cases
    run_op8(8'h05, 8'h03, 1'b0, "d_05_03");
    run_op8(8'h00, 8'h01, 1'b0, "d_00_01");
    run_op8(8'hFF, 8'hFF, 1'b1, "d_FF_FF_1");
    run_op8(8'h10, 8'h0F, 1'b1, "d_10_0F_1");
    run_op8(8'h80, 8'h7F, 1'b0, "d_80_7F");
    run_op8(8'h00, 8'hFF, 1'b1, "d_00_FF_1");

    // Random operands
    for (int n = 0; n < 24; n++) begin
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), "rnd");
    end

    // start held high with operands churning mid-run
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h37; bus8.b = 8'h12; bus8.bin = 1'b0;
    d1 = -1;
    d2 = -1;
    for (int cyc = 1; cyc <= 40 && d2 < 0; cyc++) begin
      @(negedge clk);
      if (bus8.done && d1 < 0) begin
        d1 = cyc;
        check("hold_first_lat", 64'(cyc), 64'd9);
        check("hold_first_diff", 64'(bus8.diff), 64'h25);
        check("hold_first_bout", 64'(bus8.bout), 64'd0);
        bus8.a = 8'h44; bus8.b = 8'h11; bus8.bin = 1'b1;
      end else if (bus8.done) begin
        d2 = cyc;
        check("hold_period", 64'(d2 - d1), 64'd10);
        check("hold_second_diff", 64'(bus8.diff), 64'h32);
        check("hold_second_bout", 64'(bus8.bout), 64'd0);
        bus8.start = 1'b0;
      end else if (d1 < 0) begin
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.bin = 1'($urandom);
      end
    end
    if (d2 < 0) check("hold_timeout", 64'd0, 64'd1);
    bus8.start = 1'b0;
    last_d8 = 8'h32;
    last_b8 = 1'b0;
    repeat (3) @(negedge clk);

    // Previous result 0xFF so a clear by reset is visible
    run_op8(8'hFF, 8'hFF, 1'b1, "pre_rst");

    // Reset in RUN cycle 4
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h05; bus8.b = 8'h03; bus8.bin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_before_rst", 64'(bus8.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus8.busy), 64'd0);
    check("mid_rst_done", 64'(bus8.done), 64'd0);
    check("mid_rst_diff", 64'(bus8.diff), 64'd0);
    check("mid_rst_bout", 64'(bus8.bout), 64'd0);
    last_d8 = '0;
    last_b8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus8.done) done_cnt++;
    end
    check("mid_rst_no_done", 64'(done_cnt), 64'd0);
    run_op8(8'h05, 8'h03, 1'b0, "post_rst");

    // WIDTH=4 exhaustive sweep
    for (int v = 0; v < 512; v++) begin
      run_op4(4'(v >> 5), 4'(v >> 1), 1'(v));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_serial_subtractor
